// File: rtl/tower_pkg.sv
// Shared GF(2^8) binary-tower types and constants used by the multiplier
// and by the multiplier scheduler.
package tower_pkg;

  localparam int GF8_W = 8;

  typedef logic [GF8_W-1:0] gf8_t;

  localparam gf8_t GF8_ZERO = 8'h00;
  localparam gf8_t GF8_ONE  = 8'h01;

endpackage

// File: rtl/tower_mul8.sv
// Purely combinational GF(2^8) binary-tower multiplier (Karatsuba at each level).
// Tower: X0^2 = X0 + 1, X1^2 = X1*X0 + 1, X2^2 = X2*X1 + 1; bit 0 is basis element 1.
module tower_mul8
  import tower_pkg::*;
(
  input  gf8_t a,
  input  gf8_t b,
  output gf8_t p
);

  // GF(4): lo = a0b0 + a1b1, hi = cross + a1b1 collapses to (a0+a1)(b0+b1) + a0b0.
  function automatic logic [1:0] mul2(input logic [1:0] x, input logic [1:0] y);
    logic [1:0] r;
    r[0] = (x[0] & y[0]) ^ (x[1] & y[1]);
    r[1] = ((x[0] ^ x[1]) & (y[0] ^ y[1])) ^ (x[0] & y[0]);
    return r;
  endfunction

  // Multiply a GF(4) element by its generator X0.
  function automatic logic [1:0] mulx2(input logic [1:0] c);
    return {c[0] ^ c[1], c[1]};
  endfunction

  function automatic logic [3:0] mul4(input logic [3:0] x, input logic [3:0] y);
    logic [1:0] p0;
    logic [1:0] p1;
    logic [1:0] pm;
    p0 = mul2(x[1:0], y[1:0]);
    p1 = mul2(x[3:2], y[3:2]);
    pm = mul2(x[1:0] ^ x[3:2], y[1:0] ^ y[3:2]);
    return {pm ^ p0 ^ p1 ^ mulx2(p1), p0 ^ p1};
  endfunction

  // Multiply a GF(16) element by its generator X1.
  function automatic logic [3:0] mulx4(input logic [3:0] c);
    return {c[1:0] ^ mulx2(c[3:2]), c[3:2]};
  endfunction

  logic [3:0] p_lo;
  logic [3:0] p_hi;
  logic [3:0] p_mid;

  always_comb begin
    p_lo  = mul4(a[3:0], b[3:0]);
    p_hi  = mul4(a[7:4], b[7:4]);
    p_mid = mul4(a[3:0] ^ a[7:4], b[3:0] ^ b[7:4]);
    p     = {p_mid ^ p_lo ^ p_hi ^ mulx4(p_hi), p_lo ^ p_hi};
  end

endmodule

// File: rtl/tower_mul_sched.sv
// Round-robin scheduler sharing one tower_mul8 among N_REQ requesters; products
// are queued with the requester index in a 2-entry response FIFO.
module tower_mul_sched
  import tower_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_a,
  input  logic [8*N_REQ-1:0]   req_b,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output gf8_t                 rsp_data,
  output logic [ID_W-1:0]      rsp_id
);

  // Handshakes: a beat transfers on a rising edge where valid and ready are both
  // high; ready never depends on the same-cycle ready of the downstream side.

  logic [ID_W-1:0] ptr;
  logic [1:0]      fifo_count;
  gf8_t            slot_data [2];
  logic [ID_W-1:0] slot_id   [2];

  logic            grant_found;
  logic [ID_W-1:0] grant_idx;
  gf8_t            grant_a;
  gf8_t            grant_b;
  gf8_t            product;
  logic            admit;
  logic            push;
  logic            pop;

  // Two passes: first the indices at or above ptr, then wrap to the bottom.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!grant_found && req_valid[i] && (ptr <= ID_W'(i))) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(i);
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!grant_found && req_valid[i]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(i);
      end
    end
  end

  assign admit = (fifo_count != 2'd2) && !rst;
  assign push  = grant_found && admit;
  assign pop   = rsp_valid && rsp_ready;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_ready[i] = push && (grant_idx == ID_W'(i));
    end
  end

  always_comb begin
    grant_a = GF8_ZERO;
    grant_b = GF8_ZERO;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        grant_a = req_a[8*i +: 8];
        grant_b = req_b[8*i +: 8];
      end
    end
  end

  tower_mul8 u_mul (
    .a (grant_a),
    .b (grant_b),
    .p (product)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (push) begin
      ptr <= (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
    end
  end

  // Slot 0 is always the head, so the output is a plain register read.
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_count   <= 2'd0;
      slot_data[0] <= GF8_ZERO;
      slot_data[1] <= GF8_ZERO;
      slot_id[0]   <= '0;
      slot_id[1]   <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (fifo_count == 2'd0) begin
            slot_data[0] <= product;
            slot_id[0]   <= grant_idx;
          end else begin
            slot_data[1] <= product;
            slot_id[1]   <= grant_idx;
          end
          fifo_count <= fifo_count + 2'd1;
        end
        2'b01: begin
          slot_data[0] <= slot_data[1];
          slot_id[0]   <= slot_id[1];
          fifo_count   <= fifo_count - 2'd1;
        end
        2'b11: begin
          if (fifo_count == 2'd1) begin
            slot_data[0] <= product;
            slot_id[0]   <= grant_idx;
          end else begin
            slot_data[0] <= slot_data[1];
            slot_id[0]   <= slot_id[1];
            slot_data[1] <= product;
            slot_id[1]   <= grant_idx;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign rsp_valid = (fifo_count != 2'd0);
  assign rsp_data  = slot_data[0];
  assign rsp_id    = slot_id[0];

endmodule
